serial_master_port: RTL and testbench
=====================================

Name: serial_master_port

Overview:
- Initiator end of the serial system bus. It is the counterpart of the slave port.
- A host latches one read or write request into the block. The block handshakes with master_valid/slave_ready, then serializes address, write data and burst control LSB-first on three parallel lines.
- For reads it waits out any split and deserializes the returned byte(s) from the slave's tx line.
- It reports each read byte, completion and timeout errors back to the host.

Parameters:
ADDR_W, 12, address bits sent on tx_address
DATA_W, 8, data bits per write frame and per read byte
LEN_W, 12, burst length field width; burst word = {len, burst_en}, 13 bits
TIMEOUT, 255, maximum wait cycles in REQ, WAIT_DATA or SPLIT before an error abort

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clock clk
start  in  1  host request strobe, sampled only in IDLE
rw  in  1  1=read, 0=write
addr_in  in  12  target address
wdata_in  in  8  write data
burst_en  in  1  read burst request
burst_len  in  12  number of bytes in the read burst
slave_ready  in  1  slave can accept frame / is ready
slave_valid  in  1  slave is presenting read data
split_en  in  1  slave split indication
rx_data  in  1  serial read data from slave (slave tx_data)
master_valid  out  1  request frame valid
master_ready  out  1  master ready to receive a read byte
read_en  out  1  read transaction in progress
write_en  out  1  write transaction in progress
tx_address  out  1  serial address
tx_data  out  1  serial write data
tx_burst  out  1  serial burst word
rdata  out  8  last received byte
rdata_valid  out  1  one-cycle pulse, rdata updated
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = timeout abort

Behaviour:
- Reset: async. All outputs, counters and rdata go to 0; state goes to IDLE. Reset mid-transaction aborts with no done pulse.
- States: IDLE, REQ, FRAME, WAIT_DATA, SPLIT, RX, GAP, DONE. All outputs are registered.
- IDLE:
  - On start=1, latch rw, addr, wdata and the burst word, then go to REQ.
  - For writes the burst word is forced to 0.
  - For a read with burst_en=1 and burst_len=0, treat the length as 1.
  - start is ignored outside IDLE.
- REQ:
  - master_valid=1; read_en=rw, write_en=~rw; bit 0 of each field is driven.
  - The first cycle with master_valid&slave_ready is frame cycle k=0. Go to FRAME with index=1.
- FRAME: one bit per cycle, no stall, for k=1..12.
  - tx_address=addr[k] for k<12, else 0.
  - tx_burst=burst[k] for k<=12.
  - tx_data=wdata[k] for k<8 on writes, 0 otherwise.
  - After k=12, drop master_valid. Writes go to DONE; reads go to WAIT_DATA.
- WAIT_DATA: master_ready=1.
  - split_en=1 goes to SPLIT; split_en has priority over a simultaneous slave_valid.
  - slave_valid=1 (with master_ready=1) starts byte reception: rx_data is sampled as bit 0 in that cycle, then go to RX.
- SPLIT: master_ready=0 and read_en held. Stay until split_en=0 and slave_valid=1, then return to WAIT_DATA.
- RX:
  - Sample bits 1..7 on the next 7 consecutive cycles, LSB-first.
  - After bit 7: rdata is updated and rdata_valid pulses on the following cycle; byte count increments.
  - If count==length (1 for non-burst), go to DONE; else go to GAP.
- GAP: master_ready=0 for exactly 1 cycle, then WAIT_DATA for the next byte.
- DONE:
  - done=1 for 1 cycle; read_en and write_en drop in the same cycle.
  - For reads, the final rdata_valid and done coincide.
  - Next state is IDLE.
- Timeout:
  - The cycle counter clears on entry to REQ, WAIT_DATA or SPLIT.
  - When it reaches TIMEOUT, go to DONE with err=1.
  - rdata retains its last value on a timeout abort.
- Latency: a write with slave_ready held high and start at cycle 0 gives REQ at cycle 1 (accepted), frame k=0..12 at cycles 1..13, done at cycle 14.
- Widths: byte count is LEN_W bits; the timeout counter is sized for TIMEOUT. No wrap-around is allowed before the compare.

Test Plan:
- Write addr=0xA5C, wdata=0x3B, slave_ready=1 -> tx_address shows 0,0,1,1,1,0,1,0,0,1,0,1 on k=0..11; tx_data shows 1,1,0,1,1,1,0,0 on k=0..7; tx_burst=0 throughout; done at cycle 14, err=0.
- Read addr=0x010, slave_valid after 3 idle cycles serving byte 0xC6 -> rdata=0xC6, rdata_valid coinciding with done, read_en low after done.
- Read, split_en high 20 cycles then slave_valid with 0x81 -> master_ready=0 throughout split; rdata=0x81; err=0.
- Burst read len=3 serving bytes 0x11,0x22,0x33 -> three rdata_valid pulses in order; 1-cycle master_ready gap between bytes; tx_burst word = 0b0000000000111 LSB-first.
- slave_ready held 0 for 300 cycles after start -> done with err=1 at TIMEOUT; master_valid dropped; also start pulsed while busy is ignored.
- Assert reset at frame cycle k=5 -> all outputs 0 immediately, no done; a new write after release completes normally.

Source files
------------

// File: rtl/serial_master_port.sv
// serial_master_port: initiator end of the serial bus; serializes one host request LSB-first and
// deserializes returned read bytes, reporting completion and timeout aborts.
module serial_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              burst_en,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              slave_ready,
  input  logic              slave_valid,
  input  logic              split_en,
  input  logic              rx_data,
  output logic              master_valid,
  output logic              master_ready,
  output logic              read_en,
  output logic              write_en,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int BW = LEN_W + 1;
  localparam int FL = (ADDR_W > BW ? ADDR_W : BW) - 1;
  localparam int IW = $clog2(FL + 1 > DATA_W ? FL + 1 : DATA_W);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, FRAME, WAIT_DATA, SPLIT, RX, GAP, DONE} state_t;
  state_t state, nxt;

  logic              rw_q, rw_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [BW-1:0]     burst_q, burst_n;
  logic [LEN_W-1:0]  len_q, len_n, len_fix;
  logic [IW-1:0]     idx, idx_n, kk;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [LEN_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [DATA_W-2:0] sh, sh_n;
  logic [DATA_W-1:0] rdata_n;
  logic              rdv_n, err_n, tout, in_frame, active;
  logic              a_bit, d_bit, b_bit;

  assign tout     = tcnt == TW'(TIMEOUT);
  assign cnt_inc  = cnt + LEN_W'(1);
  assign len_fix  = (burst_en && burst_len == '0) ? LEN_W'(1) : burst_len;

  always_comb begin
    nxt     = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    cnt_n   = cnt;
    sh_n    = sh;
    rdata_n = rdata;
    rdv_n   = 1'b0;
    err_n   = 1'b0;
    rw_n    = rw_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    burst_n = burst_q;
    len_n   = len_q;
    case (state)
      IDLE: if (start) begin
        nxt     = REQ;
        tcnt_n  = '0;
        cnt_n   = '0;
        rw_n    = rw;
        addr_n  = addr_in;
        wdata_n = wdata_in;
        burst_n = rw ? {len_fix, burst_en} : '0;
        len_n   = (rw && burst_en) ? len_fix : LEN_W'(1);
      end
      REQ:
        if (tout) begin
          nxt   = DONE;
          err_n = 1'b1;
        end else if (slave_ready) begin
          nxt   = FRAME;
          idx_n = IW'(1);
        end else tcnt_n = tcnt + TW'(1);
      FRAME:
        if (idx == IW'(FL)) begin
          nxt    = rw_q ? WAIT_DATA : DONE;
          tcnt_n = '0;
        end else idx_n = idx + IW'(1);
      WAIT_DATA:
        if (tout) begin
          nxt   = DONE;
          err_n = 1'b1;
        end else if (split_en) begin
          nxt    = SPLIT;
          tcnt_n = '0;
        end else if (slave_valid) begin
          nxt   = RX;
          idx_n = IW'(1);
          sh_n  = {rx_data, sh[DATA_W-2:1]};
        end else tcnt_n = tcnt + TW'(1);
      SPLIT:
        if (tout) begin
          nxt   = DONE;
          err_n = 1'b1;
        end else if (!split_en && slave_valid) begin
          nxt    = WAIT_DATA;
          tcnt_n = '0;
        end else tcnt_n = tcnt + TW'(1);
      RX:
        if (idx == IW'(DATA_W - 1)) begin
          rdata_n = {rx_data, sh};
          rdv_n   = 1'b1;
          cnt_n   = cnt_inc;
          nxt     = (cnt_inc == len_q) ? DONE : GAP;
        end else begin
          sh_n  = {rx_data, sh[DATA_W-2:1]};
          idx_n = idx + IW'(1);
        end
      GAP: begin
        nxt    = WAIT_DATA;
        tcnt_n = '0;
      end
      DONE: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign in_frame = nxt == REQ || nxt == FRAME;
  assign active   = nxt inside {REQ, FRAME, WAIT_DATA, SPLIT, RX, GAP};
  assign kk       = (nxt == FRAME) ? idx_n : '0;
  assign a_bit    = |(addr_n & (ADDR_W'(1) << kk));
  assign d_bit    = |(wdata_n & (DATA_W'(1) << kk));
  assign b_bit    = |(burst_n & (BW'(1) << kk));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      tcnt         <= '0;
      cnt          <= '0;
      sh           <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      burst_q      <= '0;
      len_q        <= '0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      tx_address   <= 1'b0;
      tx_data      <= 1'b0;
      tx_burst     <= 1'b0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= nxt;
      idx          <= idx_n;
      tcnt         <= tcnt_n;
      cnt          <= cnt_n;
      sh           <= sh_n;
      rw_q         <= rw_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      burst_q      <= burst_n;
      len_q        <= len_n;
      master_valid <= in_frame;
      master_ready <= nxt == WAIT_DATA || nxt == RX;
      read_en      <= active & rw_n;
      write_en     <= active & ~rw_n;
      tx_address   <= in_frame & a_bit;
      tx_data      <= in_frame & ~rw_n & d_bit;
      tx_burst     <= in_frame & b_bit;
      rdata        <= rdata_n;
      rdata_valid  <= rdv_n;
      busy         <= nxt != IDLE;
      done         <= nxt == DONE;
      err          <= err_n;
    end
  end
endmodule

// File: tb/tb_serial_master_port.sv
// tb_serial_master_port: drives host and slave sides of serial_master_port, predicting every output
// from the transaction rules (frame bit k of each field, byte timing, timeout cycle).
module tb_serial_master_port;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [11:0] addr_in = '0, burst_len = '0;
  logic [7:0]  wdata_in = '0;
  logic        burst_en = 1'b0, slave_ready = 1'b0, slave_valid = 1'b0, split_en = 1'b0, rx_data = 1'b0;
  logic        master_valid, master_ready, read_en, write_en, tx_address, tx_data, tx_burst;
  logic [7:0]  rdata;
  logic        rdata_valid, busy, done, err;

  int          tests = 0, errors = 0, done_cyc = 0;
  logic [11:0] cap_a;
  logic [7:0]  cap_d;
  logic [12:0] cap_b;
  logic [7:0]  srv[8];
  logic [7:0]  got[$];

  serial_master_port dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr_in(addr_in), .wdata_in(wdata_in),
    .burst_en(burst_en), .burst_len(burst_len), .slave_ready(slave_ready), .slave_valid(slave_valid),
    .split_en(split_en), .rx_data(rx_data), .master_valid(master_valid), .master_ready(master_ready),
    .read_en(read_en), .write_en(write_en), .tx_address(tx_address), .tx_data(tx_data),
    .tx_burst(tx_burst), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One complete transaction: cycle 0 is the start cycle, expectations follow the bus rules.
  task automatic txn(input logic r, input logic [11:0] a, input logic [7:0] wd, input logic ben,
                     input logic [11:0] bl, input int rdly, input int sp, input int dd);
    int len, cyc;
    logic [12:0] bw;
    len = (r && ben) ? ((bl == 0) ? 1 : int'(bl)) : 1;
    bw  = r ? {((ben && bl == 0) ? 12'd1 : bl), ben} : 13'd0;
    got.delete();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_mv", master_valid, 0);
    start = 1; rw = r; addr_in = a; wdata_in = wd; burst_en = ben; burst_len = bl;
    slave_ready = 0; slave_valid = 0; split_en = 0; rx_data = 0;
    cyc = 0;
    for (int w = 0; w <= rdly; w++) begin
      @(negedge clk); cyc++;
      start = 0; rw = 1'($urandom); addr_in = 12'($urandom); wdata_in = 8'($urandom);
      burst_en = 1'($urandom); burst_len = 12'($urandom);
      chk("req_mv", master_valid, 1);
      chk("req_busy", busy, 1);
      chk("req_rd", read_en, r);
      chk("req_wr", write_en, !r);
      chk("req_mr", master_ready, 0);
      chk("req_addr", tx_address, a[0]);
      chk("req_data", tx_data, !r && wd[0]);
      chk("req_burst", tx_burst, bw[0]);
      slave_ready = (w == rdly);
    end
    cap_a[0] = tx_address; cap_d[0] = tx_data; cap_b[0] = tx_burst;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); cyc++;
      slave_ready = 1'($urandom);
      chk("frm_mv", master_valid, 1);
      chk("frm_addr", tx_address, (k < 12) ? a[k] : 1'b0);
      chk("frm_data", tx_data, (!r && k < 8) ? wd[k] : 1'b0);
      chk("frm_burst", tx_burst, bw[k]);
      chk("frm_mr", master_ready, 0);
      chk("frm_done", done, 0);
      if (k < 12) cap_a[k] = tx_address;
      if (k < 8) cap_d[k] = tx_data;
      cap_b[k] = tx_burst;
    end
    slave_ready = 0;
    if (!r) begin
      @(negedge clk); cyc++;
      chk("wr_done", done, 1);
      chk("wr_err", err, 0);
      chk("wr_mv", master_valid, 0);
      chk("wr_we", write_en, 0);
      chk("wr_busy", busy, 1);
      chk("wr_rdv", rdata_valid, 0);
      done_cyc = cyc;
    end else begin
      for (int i = 0; i < len; i++) begin
        @(negedge clk); cyc++;
        for (int d = 0; d < dd; d++) begin
          chk("wait_mr", master_ready, 1);
          chk("wait_rdv", rdata_valid, 0);
          chk("wait_rd", read_en, 1);
          @(negedge clk); cyc++;
        end
        if (sp > 0 && i == 0) begin
          chk("presplit_mr", master_ready, 1);
          split_en = 1;
          for (int s = 1; s < sp; s++) begin
            @(negedge clk); cyc++;
            chk("split_mr", master_ready, 0);
            chk("split_rd", read_en, 1);
          end
          @(negedge clk); cyc++;
          chk("split_mr", master_ready, 0);
          split_en = 0; slave_valid = 1; rx_data = srv[i][0];
          @(negedge clk); cyc++;
        end else begin
          slave_valid = 1; rx_data = srv[i][0];
        end
        chk("hs_mr", master_ready, 1);
        for (int j = 1; j < 8; j++) begin
          @(negedge clk); cyc++;
          slave_valid = 0; rx_data = srv[i][j];
          chk("rx_mr", master_ready, 1);
          chk("rx_rdv", rdata_valid, 0);
        end
        @(negedge clk); cyc++;
        rx_data = 1'($urandom);
        chk("byte_rdv", rdata_valid, 1);
        chk("byte_val", rdata, srv[i]);
        chk("byte_done", done, i == len - 1);
        chk("byte_err", err, 0);
        chk("byte_gap_mr", master_ready, 0);
        chk("byte_rd", read_en, i != len - 1);
        got.push_back(rdata);
        done_cyc = cyc;
      end
    end
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  // Silent slave: the abort must land exactly TIMEOUT+1 cycles into the waiting state.
  task automatic tmo(input logic r, input logic [7:0] prev);
    int dc;
    dc = r ? 270 : 257;
    @(negedge clk);
    start = 1; rw = r; addr_in = 12'h123; wdata_in = 8'h45; burst_en = 0; burst_len = 0;
    slave_ready = r; slave_valid = 0; split_en = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == 10); rw = (c == 10) ? !r : r;
      if (c < dc) begin
        chk("tmo_busy", busy, 1);
        chk("tmo_early", done, 0);
      end
      if (!r && c < dc) chk("tmo_mv", master_valid, 1);
      if (r && c >= 14 && c < dc) chk("tmo_mr", master_ready, 1);
      if (c == dc) begin
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_mv_drop", master_valid, 0);
        chk("tmo_rd", read_en, 0);
        chk("tmo_wr", write_en, 0);
        chk("tmo_rdata", rdata, prev);
        chk("tmo_rdv", rdata_valid, 0);
      end
      if (c > dc) begin
        chk("tmo_idle", busy, 0);
        chk("tmo_nodone", done, 0);
      end
    end
    slave_ready = 0; start = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_mv", master_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mr", master_ready, 0);
    @(negedge clk);
    reset = 0;

    txn(0, 12'hA5C, 8'h3B, 0, 12'd0, 0, 0, 0);
    chk("lit_addr", cap_a, 12'hA5C);
    chk("lit_wdata", cap_d, 8'h3B);
    chk("lit_wburst", cap_b, 13'h0000);
    chk("lit_wdone", done_cyc, 14);

    srv[0] = 8'hC6;
    txn(1, 12'h010, 8'h00, 0, 12'd0, 0, 0, 3);
    chk("lit_c6", got[0], 8'hC6);
    chk("lit_rdone", done_cyc, 25);

    srv[0] = 8'h81;
    txn(1, 12'h3F0, 8'h00, 0, 12'd0, 1, 20, 0);
    chk("lit_81", got[0], 8'h81);

    srv[0] = 8'h11; srv[1] = 8'h22; srv[2] = 8'h33;
    txn(1, 12'h777, 8'h00, 1, 12'd3, 0, 0, 0);
    chk("lit_bword", cap_b, 13'b0000000000111);
    chk("lit_bcount", got.size(), 3);
    chk("lit_b2", got[2], 8'h33);

    tmo(0, 8'h33);
    tmo(1, 8'h33);

    @(negedge clk);
    start = 1; rw = 0; addr_in = 12'hFFF; wdata_in = 8'hFF; slave_ready = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
    end
    chk("pre_rst_addr", tx_address, 1);
    reset = 1;
    #1;
    chk("arst_mv", master_valid, 0);
    chk("arst_addr", tx_address, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_we", write_en, 0);
    chk("arst_rdata", rdata, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("arst_nodone", done, 0);
    end
    reset = 0; slave_ready = 0;
    txn(0, 12'h5A1, 8'hC3, 0, 12'd0, 2, 0, 0);
    chk("lit_post_rst", cap_a, 12'h5A1);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) srv[i] = 8'($urandom);
      txn(1'($urandom), 12'($urandom), 8'($urandom), 1'($urandom), 12'($urandom_range(0, 3)),
          int'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0,
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
